line_compactor: RTL

//  Parametrised single-pass line-clear engine for the board RAM. On start, scans rows bottom (H-1) to top (0).

---
 rtl/tetris_pkg.sv | 21 ++
 rtl/board_addr.sv | 19 +
 rtl/line_compactor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board constants and line-clear FSM state encoding
package tetris_pkg;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 24;
    localparam int DEF_CELL_W  = 6;
    localparam int DEF_ADDR_W  = 8;

    // A cell holding this value is empty; any other value is an occupied cell.
    localparam int EMPTY_CELL  = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_WR   = 3'd3,
        S_FILL = 3'd4,
        S_DONE = 3'd5
    } lc_state_e;

endpackage

// File: rtl/board_addr.sv
// rtl/board_addr.sv - (x, y) cell coordinate to linear board RAM address
module board_addr
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int X_W     = 4,
    parameter int Y_W     = 5
) (
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(BOARD_W);

    assign addr_o = ADDR_W'(y_i) * ROW_STRIDE + ADDR_W'(x_i);

endmodule

// File: rtl/line_compactor.sv
// rtl/line_compactor.sv - single-pass line-clear engine for the board RAM
module line_compactor
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int CELL_W  = DEF_CELL_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = $clog2(BOARD_H + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [CELL_W-1:0]  ram_q,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [CELL_W-1:0]  ram_data,
    output logic               ram_wren,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   rows_cleared,
    output logic [BOARD_H-1:0] cleared_mask
);

    // Row pointers carry one extra bit so that stepping past row 0 shows up as -1.
    localparam int PTR_W = $clog2(BOARD_H) + 1;
    localparam int Y_W   = PTR_W - 1;
    localparam int X_W   = $clog2(BOARD_W);
    localparam int C_W   = $clog2(BOARD_W + RAM_LAT + 1);

    localparam logic [C_W-1:0]          LAST_X  = C_W'(BOARD_W - 1);
    localparam logic [C_W-1:0]          LAST_RD = C_W'(BOARD_W + RAM_LAT - 1);
    localparam logic [C_W-1:0]          LAT_C   = C_W'(RAM_LAT);
    localparam logic signed [PTR_W-1:0] TOP_ROW = PTR_W'(BOARD_H - 1);
    localparam logic signed [PTR_W-1:0] ONE     = PTR_W'(1);

    lc_state_e               state_q, state_d;
    logic signed [PTR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [C_W-1:0]          cnt_q, cnt_d;
    logic                    any_empty_q, any_empty_d;
    logic [CNT_W-1:0]        rows_q, rows_d;
    logic [BOARD_H-1:0]      mask_q, mask_d;
    logic [CELL_W-1:0]       row_buf_q [BOARD_W];

    logic                    capture;
    logic [C_W-1:0]          cap_idx;
    logic [X_W-1:0]          cap_x;
    logic [X_W-1:0]          wr_x;
    logic                    advance;
    logic [C_W-1:0]          addr_x;
    logic [Y_W-1:0]          addr_y;
    logic [ADDR_W-1:0]       cell_addr;
    logic                    ram_active;

    // Read data for the cell issued RAM_LAT cycles ago arrives once the counter passes the latency.
    assign capture = (state_q == S_RD) && (cnt_q >= LAT_C);
    assign cap_idx = cnt_q - LAT_C;
    assign cap_x   = cap_idx[X_W-1:0];
    assign wr_x    = cnt_q[X_W-1:0];

    // Reads walk the source row; writes and zero-fill walk the destination row.
    always_comb begin
        addr_x = cnt_q;
        addr_y = dst_q[Y_W-1:0];
        if (state_q == S_RD) begin
            addr_y = src_q[Y_W-1:0];
            if (cnt_q > LAST_X) begin
                addr_x = LAST_X;
            end
        end
    end

    board_addr #(
        .BOARD_W (BOARD_W),
        .ADDR_W  (ADDR_W),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_board_addr (
        .x_i    (addr_x[X_W-1:0]),
        .y_i    (addr_y),
        .addr_o (cell_addr)
    );

    assign ram_active   = (state_q == S_RD) || ram_wren;
    assign ram_wren     = (state_q == S_WR) || (state_q == S_FILL);
    assign ram_addr     = ram_active ? cell_addr : '0;
    assign ram_data     = (state_q == S_WR) ? row_buf_q[wr_x] : CELL_W'(EMPTY_CELL);
    assign busy         = (state_q == S_RD) || (state_q == S_CHK) || ram_wren;
    assign done         = (state_q == S_DONE);
    assign rows_cleared = rows_q;
    assign cleared_mask = mask_q;

    // Next-state logic: scan bottom-up, drop full rows, copy survivors down, then zero the top.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        any_empty_d = any_empty_q;
        rows_d      = rows_q;
        mask_d      = mask_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d      = '0;
                    mask_d      = '0;
                    src_d       = TOP_ROW;
                    dst_d       = TOP_ROW;
                    cnt_d       = '0;
                    any_empty_d = 1'b0;
                    state_d     = S_RD;
                end
            end
            S_RD: begin
                if (capture && (ram_q == CELL_W'(EMPTY_CELL))) begin
                    any_empty_d = 1'b1;
                end
                if (cnt_q == LAST_RD) begin
                    cnt_d   = '0;
                    state_d = S_CHK;
                end else begin
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            S_CHK: begin
                if (!any_empty_q) begin
                    rows_d                 = rows_q + CNT_W'(1);
                    mask_d[src_q[Y_W-1:0]] = 1'b1;
                    src_d                  = src_q - ONE;
                    advance                = 1'b1;
                end else if (src_q == dst_q) begin
                    src_d   = src_q - ONE;
                    dst_d   = dst_q - ONE;
                    advance = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (cnt_q == LAST_X) begin
                    src_d   = src_q - ONE;
                    dst_d   = dst_q - ONE;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            S_FILL: begin
                if (cnt_q == LAST_X) begin
                    cnt_d = '0;
                    dst_d = dst_q - ONE;
                    if (dst_q == '0) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // After a row is resolved: next row, or zero-fill, or finish when nothing was cleared.
        if (advance) begin
            cnt_d       = '0;
            any_empty_d = 1'b0;
            if (src_d[PTR_W-1]) begin
                state_d = dst_d[PTR_W-1] ? S_DONE : S_FILL;
            end else begin
                state_d = S_RD;
            end
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            src_q       <= TOP_ROW;
            dst_q       <= TOP_ROW;
            cnt_q       <= '0;
            any_empty_q <= 1'b0;
            rows_q      <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            any_empty_q <= any_empty_d;
            rows_q      <= rows_d;
            mask_q      <= mask_d;
        end
    end

    // Row buffer holds the source row between its read and its write-back.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BOARD_W; i++) begin
                row_buf_q[i] <= '0;
            end
        end else if (capture) begin
            row_buf_q[cap_x] <= ram_q;
        end
    end

endmodule
